// File: rtl/text_ovl_pkg.sv
// Shared types and constants for the font-ROM text overlay: slot record, cell geometry,
// reset-default slot contents and config FSM encoding.
package text_ovl_pkg;

  localparam int unsigned NSLOT       = 3;
  localparam int unsigned CELL_W_LOG2 = 4;
  localparam int unsigned CELL_H_LOG2 = 5;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StCommit = 1'b1;

  typedef struct packed {
    logic [6:0] chr;
    logic [3:0] row;
    logic [5:0] col;
    logic [2:0] colour;
    logic       en;
    logic       blink;
  } slot_cfg_t;

  // Index 0 is the rightmost element: slot0 'J', slot1 'D', slot2 'M'.
  localparam logic [NSLOT-1:0][6:0] DEF_CHAR = {7'h4D, 7'h44, 7'h4A};
  localparam logic [NSLOT-1:0][3:0] DEF_ROW  = {4'd8, 4'd6, 4'd4};
  localparam logic [NSLOT-1:0][5:0] DEF_COL  = {6'd18, 6'd10, 6'd4};

  function automatic slot_cfg_t slot_default(input int idx);
    slot_cfg_t d;
    d.chr    = DEF_CHAR[idx];
    d.row    = DEF_ROW[idx];
    d.col    = DEF_COL[idx];
    d.colour = 3'b111;
    d.en     = 1'b1;
    d.blink  = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/text_ovl_slot_regs.sv
// Shadow and active slot register file; shadow takes config writes, active is loaded
// from shadow in one shot on commit so the display never tears mid-frame.
module text_ovl_slot_regs
  import text_ovl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_slot,
  input  slot_cfg_t                   wr_data,
  input  logic                        commit,
  output slot_cfg_t [NSLOT-1:0]       active
);

  slot_cfg_t [NSLOT-1:0] shadow_q;
  slot_cfg_t [NSLOT-1:0] active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        shadow_q[i] <= slot_default(i);
        active_q[i] <= slot_default(i);
      end
    end else begin
      if (wr_en && (wr_slot < 2'(NSLOT))) begin
        shadow_q[wr_slot] <= wr_data;
      end
      if (commit) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active = active_q;

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text overlay scheduler: config FSM, blink counter, per-slot hit and priority resolve,
// and a two-stage pipeline aligned to the synchronous font ROM.
module text_overlay_ctrl
  import text_ovl_pkg::*;
#(
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_end,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_slot,
  input  logic [6:0]  cfg_char,
  input  logic [3:0]  cfg_row,
  input  logic [5:0]  cfg_col,
  input  logic [2:0]  cfg_colour,
  input  logic        cfg_en,
  input  logic        cfg_blink,
  output logic        cfg_err,
  output logic [10:0] rom_addr,
  input  logic [7:0]  font_word,
  output logic [2:0]  text_on,
  output logic [2:0]  rgb_text,
  output logic        video_on_d
);

  logic [0:0]           state_q, state_d;
  logic                 dirty_q, dirty_d;
  logic                 ready_q, err_q;
  logic [BLINK_BIT:0]   frame_cnt_q;
  logic                 cfg_acc, wr_legal, commit;
  slot_cfg_t            wr_data;
  slot_cfg_t [NSLOT-1:0] active;

  assign cfg_acc  = cfg_valid & ready_q;
  assign wr_legal = cfg_acc & (cfg_slot != 2'd3);
  assign commit   = (state_q == StCommit);

  always_comb begin
    wr_data.chr    = cfg_char;
    wr_data.row    = cfg_row;
    wr_data.col    = cfg_col;
    wr_data.colour = cfg_colour;
    wr_data.en     = cfg_en;
    wr_data.blink  = cfg_blink;
  end

  // A write landing on the frame_end cycle is already in shadow when COMMIT copies it.
  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    case (state_q)
      StIdle: begin
        if (wr_legal) dirty_d = 1'b1;
        if (frame_end && (dirty_q || wr_legal)) state_d = StCommit;
      end
      default: begin
        dirty_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dirty_q     <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      ready_q <= (state_d == StIdle);
      err_q   <= cfg_acc & (cfg_slot == 2'd3);
      if (frame_end) frame_cnt_q <= frame_cnt_q + (BLINK_BIT + 1)'(1);
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

  text_ovl_slot_regs u_slot_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_legal),
    .wr_slot (cfg_slot),
    .wr_data (wr_data),
    .commit  (commit),
    .active  (active)
  );

  logic [NSLOT-1:0] hit;
  logic [6:0]       win_chr;
  logic [2:0]       win_colour;

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      hit[i] = active[i].en && !pixel_y[9] &&
               (pixel_y[CELL_H_LOG2 +: 4] == active[i].row) &&
               (pixel_x[CELL_W_LOG2 +: 6] == active[i].col) &&
               !(active[i].blink && frame_cnt_q[BLINK_BIT]);
    end
  end

  // Walk from the highest slot down so the lowest-numbered hit wins.
  always_comb begin
    win_chr    = active[0].chr;
    win_colour = 3'b000;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_chr    = active[i].chr;
        win_colour = active[i].colour;
      end
    end
  end

  logic [10:0]      rom_addr_q;
  logic [2:0]       colour_s1_q, colour_s2_q;
  logic [2:0]       bit_s1_q, bit_s2_q;
  logic [NSLOT-1:0] hit_s1_q, hit_s2_q;
  logic             vid_s1_q, vid_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q  <= '0;
      colour_s1_q <= '0;
      bit_s1_q    <= '0;
      hit_s1_q    <= '0;
      vid_s1_q    <= 1'b0;
      colour_s2_q <= '0;
      bit_s2_q    <= '0;
      hit_s2_q    <= '0;
      vid_s2_q    <= 1'b0;
    end else begin
      if (|hit) rom_addr_q <= {win_chr, pixel_y[CELL_H_LOG2-1:1]};
      colour_s1_q <= win_colour;
      bit_s1_q    <= pixel_x[CELL_W_LOG2-1:1];
      hit_s1_q    <= hit;
      vid_s1_q    <= video_on;
      colour_s2_q <= colour_s1_q;
      bit_s2_q    <= bit_s1_q;
      hit_s2_q    <= hit_s1_q;
      vid_s2_q    <= vid_s1_q;
    end
  end

  logic font_bit;
  // Font MSB is the leftmost pixel of the glyph row.
  assign font_bit   = font_word[~bit_s2_q];
  assign rom_addr   = rom_addr_q;
  assign rgb_text   = ((|hit_s2_q) && font_bit && vid_s2_q) ? colour_s2_q : 3'b000;
  assign text_on    = {hit_s2_q[0], hit_s2_q[1], hit_s2_q[2]};
  assign video_on_d = vid_s2_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed bench for text_overlay_ctrl with a synchronous font ROM stand-in whose glyph
// rows alternate between left-half and right-half lit.
module tb_text_overlay_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_end;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_slot;
  logic [6:0]  cfg_char;
  logic [3:0]  cfg_row;
  logic [5:0]  cfg_col;
  logic [2:0]  cfg_colour;
  logic        cfg_en, cfg_blink, cfg_err;
  logic [10:0] rom_addr;
  logic [7:0]  font_word = 8'h00;
  logic [2:0]  text_on, rgb_text;
  logic        video_on_d;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;

  always #5 clk = ~clk;

  // Even glyph rows light pixels 0..3, odd rows light pixels 4..7.
  always @(posedge clk) font_word <= rom_addr[0] ? 8'h0F : 8'hF0;

  text_overlay_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .frame_end  (frame_end),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_slot   (cfg_slot),
    .cfg_char   (cfg_char),
    .cfg_row    (cfg_row),
    .cfg_col    (cfg_col),
    .cfg_colour (cfg_colour),
    .cfg_en     (cfg_en),
    .cfg_blink  (cfg_blink),
    .cfg_err    (cfg_err),
    .rom_addr   (rom_addr),
    .font_word  (font_word),
    .text_on    (text_on),
    .rgb_text   (rgb_text),
    .video_on_d (video_on_d)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one pixel, check the ROM address after one edge and the outputs after two.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic vid, input logic [2:0] exp_on, input logic [2:0] exp_rgb,
                       input logic [6:0] exp_chr);
    @(negedge clk);
    pixel_x  = x;
    pixel_y  = y;
    video_on = vid;
    @(posedge clk); #1;
    if (exp_on != 3'b000) check_eq({tag, "_addr"}, 32'(rom_addr), 32'({exp_chr, y[4:1]}));
    @(posedge clk); #1;
    check_eq({tag, "_on"},  32'(text_on),    32'(exp_on));
    check_eq({tag, "_rgb"}, 32'(rgb_text),   32'(exp_rgb));
    check_eq({tag, "_vid"}, 32'(video_on_d), 32'(vid));
  endtask

  task automatic cfg_write(input logic [1:0] slot, input logic [6:0] chr, input logic [3:0] row,
                           input logic [5:0] col, input logic [2:0] colour, input logic en,
                           input logic blink);
    @(negedge clk);
    check_eq("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid  = 1'b1;
    cfg_slot   = slot;
    cfg_char   = chr;
    cfg_row    = row;
    cfg_col    = col;
    cfg_colour = colour;
    cfg_en     = en;
    cfg_blink  = blink;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_frame_end(input logic expect_commit);
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    fe_cnt++;
    if (expect_commit) begin
      check_eq("commit_ready_low", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      check_eq("commit_ready_back", 32'(cfg_ready), 32'd1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_end = 1'b0;
    cfg_valid = 1'b0; cfg_slot = '0; cfg_char = '0; cfg_row = '0; cfg_col = '0;
    cfg_colour = '0; cfg_en = 1'b0; cfg_blink = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(cfg_ready),  32'd0);
    check_eq("rst_on",    32'(text_on),    32'd0);
    check_eq("rst_rgb",   32'(rgb_text),   32'd0);
    check_eq("rst_vid",   32'(video_on_d), 32'd0);
    check_eq("rst_err",   32'(cfg_err),    32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_after", 32'(cfg_ready), 32'd1);

    // Default slots.
    probe("s0_tl",    10'd64,  10'd128, 1'b1, 3'b100, 3'b111, 7'h4A);
    probe("s0_dark",  10'd72,  10'd128, 1'b1, 3'b100, 3'b000, 7'h4A);
    probe("s0_odd",   10'd72,  10'd130, 1'b1, 3'b100, 3'b111, 7'h4A);
    probe("s0_mid",   10'd70,  10'd140, 1'b1, 3'b100, 3'b111, 7'h4A);
    probe("s0_br",    10'd79,  10'd159, 1'b1, 3'b100, 3'b111, 7'h4A);
    probe("s0_novid", 10'd64,  10'd128, 1'b0, 3'b100, 3'b000, 7'h4A);
    probe("s0_left",  10'd63,  10'd128, 1'b1, 3'b000, 3'b000, 7'h00);
    probe("s0_right", 10'd80,  10'd128, 1'b1, 3'b000, 3'b000, 7'h00);
    probe("s0_below", 10'd64,  10'd160, 1'b1, 3'b000, 3'b000, 7'h00);
    probe("s0_y9",    10'd64,  10'd640, 1'b1, 3'b000, 3'b000, 7'h00);
    probe("s1_def",   10'd160, 10'd192, 1'b1, 3'b010, 3'b111, 7'h44);
    probe("s2_def",   10'd290, 10'd260, 1'b1, 3'b001, 3'b111, 7'h4D);

    // Slot1 rewrite holds off until the frame boundary.
    cfg_write(2'd1, 7'h41, 4'd3, 6'd5, 3'b100, 1'b1, 1'b0);
    probe("t2_old_d", 10'd160, 10'd192, 1'b1, 3'b010, 3'b111, 7'h44);
    probe("t2_no_a",  10'd80,  10'd96,  1'b1, 3'b000, 3'b000, 7'h00);
    pulse_frame_end(1'b1);
    probe("t2_a_lit",  10'd80,  10'd96,  1'b1, 3'b010, 3'b100, 7'h41);
    probe("t2_a_dark", 10'd88,  10'd96,  1'b1, 3'b010, 3'b000, 7'h41);
    probe("t2_d_gone", 10'd160, 10'd192, 1'b1, 3'b000, 3'b000, 7'h00);

    // Slot2 moved onto slot0's cell: slot0 wins.
    cfg_write(2'd2, 7'h4D, 4'd4, 6'd4, 3'b010, 1'b1, 1'b0);
    pulse_frame_end(1'b1);
    probe("t3_overlap", 10'd64, 10'd128, 1'b1, 3'b101, 3'b111, 7'h4A);

    // Illegal slot.
    cfg_write(2'd3, 7'h7F, 4'd4, 6'd4, 3'b001, 1'b0, 1'b1);
    check_eq("t4_err_pulse", 32'(cfg_err), 32'd1);
    @(negedge clk);
    check_eq("t4_err_clear", 32'(cfg_err), 32'd0);
    pulse_frame_end(1'b0);
    probe("t4_unchanged", 10'd64, 10'd128, 1'b1, 3'b101, 3'b111, 7'h4A);

    // Slot2 blinks: visible while frame_cnt[4]==0.
    cfg_write(2'd2, 7'h4D, 4'd8, 6'd18, 3'b111, 1'b1, 1'b1);
    pulse_frame_end(1'b1);
    probe("t5_vis_early", 10'd290, 10'd260, 1'b1, 3'b001, 3'b111, 7'h4D);
    while ((fe_cnt % 32) != 15) pulse_frame_end(1'b0);
    probe("t5_vis_15", 10'd290, 10'd260, 1'b1, 3'b001, 3'b111, 7'h4D);
    pulse_frame_end(1'b0);
    probe("t5_blank_16", 10'd290, 10'd260, 1'b1, 3'b000, 3'b000, 7'h00);
    probe("t5_s0_steady", 10'd64, 10'd128, 1'b1, 3'b100, 3'b111, 7'h4A);
    while ((fe_cnt % 32) != 31) pulse_frame_end(1'b0);
    probe("t5_blank_31", 10'd290, 10'd260, 1'b1, 3'b000, 3'b000, 7'h00);
    pulse_frame_end(1'b0);
    probe("t5_vis_wrap", 10'd290, 10'd260, 1'b1, 3'b001, 3'b111, 7'h4D);

    // Write on frame_end, then reset during the resulting COMMIT.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_slot = 2'd0; cfg_char = 7'h58; cfg_row = 4'd1; cfg_col = 6'd1;
    cfg_colour = 3'b001; cfg_en = 1'b1; cfg_blink = 1'b0; frame_end = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; frame_end = 1'b0;
    check_eq("t6_commit", 32'(cfg_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", 32'(cfg_ready), 32'd0);
    check_eq("t6_rst_on",    32'(text_on),   32'd0);
    check_eq("t6_rst_rgb",   32'(rgb_text),  32'd0);
    reset = 1'b0;
    fe_cnt = 0;
    @(negedge clk);
    check_eq("t6_ready_up", 32'(cfg_ready), 32'd1);
    probe("t6_s0_def",  10'd64,  10'd128, 1'b1, 3'b100, 3'b111, 7'h4A);
    probe("t6_s1_def",  10'd160, 10'd192, 1'b1, 3'b010, 3'b111, 7'h44);
    probe("t6_s2_def",  10'd290, 10'd260, 1'b1, 3'b001, 3'b111, 7'h4D);
    probe("t6_no_x",    10'd16,  10'd32,  1'b1, 3'b000, 3'b000, 7'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
